// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, the reset NOP and the
// major opcodes that the control unit also decodes.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async reset to RESET_PC, +4 step, redirect load with the
// low two bits forced to zero. Load wins over increment.
module instr_fetch_pc_reg #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i & ~XLEN'(3);
        end else if (inc_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem read, returned word held for decode under
// valid/ready; a redirect squashes whatever is in flight or held.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               ADDR_W   = 8,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic [6:0]        OP,
    output logic [2:0]        Funct3,
    output logic [6:0]        Funct7,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd
);

    fetch_state_e     state_q;
    logic             id_valid_q;
    logic [31:0]      id_instr_q;
    logic [XLEN-1:0]  id_pc_q;
    logic [XLEN-1:0]  pc;
    logic             capture;

    // Only a response that completes the live request advances the PC.
    assign capture = (state_q == ST_WAIT) && imem_rvalid && !redirect;

    instr_fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (capture),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .pc_o      (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!redirect) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (redirect) begin
                        state_q <= imem_rvalid ? ST_FETCH : ST_DRAIN;
                    end else if (imem_rvalid) begin
                        id_instr_q <= imem_rdata;
                        id_pc_q    <= pc;
                        id_valid_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect || id_ready) begin
                        id_valid_q <= 1'b0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) state_q <= ST_FETCH;
                end
                default: state_q <= ST_FETCH;
            endcase
            if (redirect) id_valid_q <= 1'b0;
        end
    end

    assign imem_req  = (state_q == ST_FETCH) && !redirect;
    assign imem_addr = pc[ADDR_W+1:2];

    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

    assign OP     = id_instr_q[6:0];
    assign rd     = id_instr_q[11:7];
    assign Funct3 = id_instr_q[14:12];
    assign rs1    = id_instr_q[19:15];
    assign rs2    = id_instr_q[24:20];
    assign Funct7 = id_instr_q[31:25];

endmodule
